// File: rtl/music_pkg.sv
// Shared types and constants for the music note sequencer and the DDS FCW table.
package music_pkg;
  localparam int NOTE_W = 7;
  localparam logic [NOTE_W-1:0] REST_NOTE = 7'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } seq_state_t;
endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick is high while the count sits at its last value.
module tick_prescaler #(
  parameter int TICK_DIV = 781250
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_r;

  // prescale counter, wraps at LAST
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {PW{1'b0}};
    end else if (clr) begin
      cnt_r <= {PW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {PW{1'b0}};
    end else begin
      cnt_r <= cnt_r + PW'(1);
    end
  end

  assign tick = (cnt_r == LAST);
endmodule

// File: rtl/music_note_seq.sv
// Note sequencer: holds a note code on fcw_addr with gate high for its duration,
// then an articulation gap with gate low, one note per valid/ready handshake.
module music_note_seq
  import music_pkg::*;
#(
  parameter int TICK_DIV  = 781250,
  parameter int DUR_W     = 8,
  parameter int GAP_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [NOTE_W-1:0] note_code,
  input  logic [DUR_W-1:0]  note_dur,
  input  logic              stop,
  output logic [NOTE_W-1:0] fcw_addr,
  output logic              gate,
  output logic              busy,
  output logic              note_done
);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int CW = (DUR_W > GW) ? DUR_W : GW;

  seq_state_t        state_r, state_nx_s;
  logic [CW-1:0]     tick_cnt_r, tick_cnt_nx_s;
  logic [NOTE_W-1:0] fcw_nx_s;
  logic              done_nx_s, gate_nx_s, busy_nx_s;
  logic              tick_s, clr_s;

  // Prescaler idles at zero outside a note so the first tick lands TICK_DIV cycles after accept
  assign clr_s = (state_r == IDLE) || stop;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  assign note_ready = (state_r == IDLE);

  // next-state, tick counter and next registered output values
  always_comb begin
    state_nx_s    = state_r;
    tick_cnt_nx_s = tick_cnt_r;
    fcw_nx_s      = fcw_addr;
    done_nx_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (note_valid) begin
          fcw_nx_s      = note_code;
          tick_cnt_nx_s = (note_dur == {DUR_W{1'b0}}) ? CW'(1) : CW'(note_dur);
          state_nx_s    = PLAY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      PLAY: begin
        if (tick_s && (tick_cnt_r <= CW'(1))) begin
          if (GAP_TICKS > 0) begin
            tick_cnt_nx_s = CW'(GAP_TICKS);
            state_nx_s    = GAP;
          end else begin
            tick_cnt_nx_s = {CW{1'b0}};
            done_nx_s     = 1'b1;
            state_nx_s    = IDLE;
          end
        end else if (tick_s) begin
          tick_cnt_nx_s = tick_cnt_r - CW'(1);
        end else begin
          tick_cnt_nx_s = tick_cnt_r;
        end
      end
      GAP: begin
        if (tick_s && (tick_cnt_r <= CW'(1))) begin
          tick_cnt_nx_s = {CW{1'b0}};
          done_nx_s     = 1'b1;
          state_nx_s    = IDLE;
        end else if (tick_s) begin
          tick_cnt_nx_s = tick_cnt_r - CW'(1);
        end else begin
          tick_cnt_nx_s = tick_cnt_r;
        end
      end
      default: begin
        state_nx_s    = IDLE;
        tick_cnt_nx_s = {CW{1'b0}};
      end
    endcase

    // stop overrides everything, including an accept, but keeps the DDS on its last note
    if (stop) begin
      state_nx_s    = IDLE;
      tick_cnt_nx_s = {CW{1'b0}};
      fcw_nx_s      = fcw_addr;
      done_nx_s     = 1'b0;
    end else begin
      done_nx_s = done_nx_s;
    end

    gate_nx_s = (state_nx_s == PLAY) && (fcw_nx_s != REST_NOTE);
    busy_nx_s = (state_nx_s != IDLE);
  end

  // state, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      tick_cnt_r <= {CW{1'b0}};
      fcw_addr   <= REST_NOTE;
      gate       <= 1'b0;
      busy       <= 1'b0;
      note_done  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      tick_cnt_r <= tick_cnt_nx_s;
      fcw_addr   <= fcw_nx_s;
      gate       <= gate_nx_s;
      busy       <= busy_nx_s;
      note_done  <= done_nx_s;
    end
  end
endmodule

// File: tb/tb_music_note_seq.sv
// Self-checking bench for music_note_seq: table of notes with a scoreboard of
// expected note shapes, plus hand-written stop / reset / no-gap sequences.
module tb_music_note_seq;
  localparam int TD = 4;
  localparam int GT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, nv, stop, sel;
  logic [6:0] code;
  logic [7:0] dur;
  logic       v_a, v_b;
  logic       rdy_a, gate_a, busy_a, done_a, rdy_b, gate_b, busy_b, done_b;
  logic [6:0] fcw_a, fcw_b;
  logic       m_rdy, m_gate, m_busy, m_done;
  logic [6:0] m_fcw;

  assign v_a = nv & ~sel;
  assign v_b = nv & sel;
  assign m_rdy  = sel ? rdy_b  : rdy_a;
  assign m_gate = sel ? gate_b : gate_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_fcw  = sel ? fcw_b  : fcw_a;

  music_note_seq #(.TICK_DIV(TD), .DUR_W(8), .GAP_TICKS(GT)) dut_a (
    .clk(clk), .rst(rst), .note_valid(v_a), .note_ready(rdy_a), .note_code(code),
    .note_dur(dur), .stop(stop), .fcw_addr(fcw_a), .gate(gate_a), .busy(busy_a),
    .note_done(done_a));

  music_note_seq #(.TICK_DIV(TD), .DUR_W(8), .GAP_TICKS(0)) dut_b (
    .clk(clk), .rst(rst), .note_valid(v_b), .note_ready(rdy_b), .note_code(code),
    .note_dur(dur), .stop(stop), .fcw_addr(fcw_b), .gate(gate_b), .busy(busy_b),
    .note_done(done_b));

  typedef struct {logic [6:0] code; int busy_len; int gate_len;} exp_t;
  typedef struct {logic [6:0] code; logic [7:0] dur; bit hold; bit b2b;} vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   prev_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Offer a note at a negedge; returns at the negedge after the accepting edge
  task automatic handshake(input bit s, input logic [6:0] c, input logic [7:0] d, input bit hold);
    sel  = s;
    code = c;
    dur  = d;
    nv   = 1'b1;
    @(negedge clk);
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
    if (!hold) nv = 1'b0;
  endtask

  task automatic drive_note(input bit s, input logic [6:0] c, input logic [7:0] d,
                            input int gap_t, input bit hold);
    exp_t e;
    int dd;
    dd = (d == 8'd0) ? 1 : int'(d);
    e.code     = c;
    e.busy_len = (dd + gap_t) * TD;
    e.gate_len = (c != 7'd0) ? dd * TD : 0;
    sb.push_back(e);
    handshake(s, c, d, hold);
  endtask

  // Pop the expected shape and measure the note the DUT plays
  task automatic check_note();
    exp_t e;
    int n, g, glast, fbad, dones;
    e = sb.pop_front();
    n = 0; g = 0; glast = 0; fbad = 0; dones = 0;
    while (m_busy && n < 200) begin
      n++;
      if (m_gate) begin
        g++;
        glast = n;
      end
      if (m_fcw !== e.code) fbad++;
      if (m_done) dones++;
      @(negedge clk);
    end
    chk($sformatf("busy_len code=%0d", e.code), n, e.busy_len);
    chk($sformatf("gate_len code=%0d", e.code), g, e.gate_len);
    chk($sformatf("gate_contig code=%0d", e.code), glast, e.gate_len);
    chk($sformatf("fcw_hold code=%0d", e.code), fbad, 0);
    chk($sformatf("early_done code=%0d", e.code), dones, 0);
    chk($sformatf("done_pulse code=%0d", e.code), int'(m_done), 1);
    chk($sformatf("ready_after code=%0d", e.code), int'(m_rdy), 1);
    chk($sformatf("fcw_after code=%0d", e.code), int'(m_fcw), int'(e.code));
  endtask

  initial begin
    int dn;
    vecs[0] = '{7'd60, 8'd3, 1'b0, 1'b0};
    vecs[1] = '{7'd62, 8'd0, 1'b0, 1'b0};
    vecs[2] = '{7'd0,  8'd2, 1'b0, 1'b0};
    vecs[3] = '{7'd60, 8'd1, 1'b1, 1'b0};
    vecs[4] = '{7'd64, 8'd1, 1'b1, 1'b1};
    vecs[5] = '{7'd67, 8'd1, 1'b0, 1'b1};

    rst = 1'b1; nv = 1'b0; stop = 1'b0; sel = 1'b0; code = 7'd0; dur = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_fcw_a", int'(fcw_a), 0);
    chk("rst_gate_a", int'(gate_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_ready_a", int'(rdy_a), 1);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_ready_b", int'(rdy_b), 1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      drive_note(1'b0, vecs[i].code, vecs[i].dur, GT, vecs[i].hold);
      if (vecs[i].b2b) chk($sformatf("period code=%0d", vecs[i].code), acc_cyc - prev_acc, (1 + GT) * TD + 1);
      check_note();
    end
    nv = 1'b0;
    repeat (2) @(negedge clk);

    // stop at cycle 5 of a dur-3 note
    handshake(1'b0, 7'd60, 8'd3, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre_stop_gate", int'(gate_a), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", int'(busy_a), 0);
    chk("stop_gate", int'(gate_a), 0);
    chk("stop_fcw", int'(fcw_a), 60);
    chk("stop_done", int'(done_a), 0);
    chk("stop_ready", int'(rdy_a), 1);
    // stop with a valid note in IDLE must not accept
    stop = 1'b1; nv = 1'b1; code = 7'd70; dur = 8'd1;
    @(negedge clk);
    stop = 1'b0; nv = 1'b0;
    chk("stop_valid_busy", int'(busy_a), 0);
    chk("stop_valid_fcw", int'(fcw_a), 60);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_a || busy_a) dn++;
      @(negedge clk);
    end
    chk("stop_no_late_done", dn, 0);

    // no-gap build
    drive_note(1'b1, 7'd72, 8'd2, 0, 1'b0);
    check_note();
    sel = 1'b0;
    @(negedge clk);

    // reset in the middle of the gap
    handshake(1'b0, 7'd64, 8'd1, 1'b0);
    repeat (5) @(negedge clk);
    chk("gap_busy", int'(busy_a), 1);
    chk("gap_gate", int'(gate_a), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_fcw", int'(fcw_a), 0);
    chk("midrst_gate", int'(gate_a), 0);
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_done", int'(done_a), 0);
    chk("midrst_ready", int'(rdy_a), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/music_note_seq.md
# music_note_seq

Note sequencer that drives the 7-bit note index (`fcw_addr`) of the music DDS voice and gates its output. It accepts one note per handshake as a (note code, duration) pair. It holds that code on `fcw_addr` with `gate` high for the note's duration in tempo ticks, then inserts a fixed articulation gap with `gate` low. It sits between the score source (CPU mailbox or score ROM walker) and `music_dds`; the output mixer uses `gate` to mute the DDS sample.

## Interface
- `TICK_DIV`, default 781250: clk cycles per tempo tick (100 MHz / 128 Hz); must be ≥ 1.
- `DUR_W`, default 8: width of the duration field, in ticks.
- `GAP_TICKS`, default 2: articulation gap after each note, in ticks; 0 means no gap.

Ports (name, direction, width, meaning):
- `clk`, in, 1: system clock; the only clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `note_valid`, in, 1: a note is offered.
- `note_ready`, out, 1: the sequencer can accept a note.
- `note_code`, in, 7: note index to drive onto `fcw_addr`; 0 = rest.
- `note_dur`, in, DUR_W: note length in ticks; 0 is treated as 1.
- `stop`, in, 1: abort the current note or gap immediately.
- `fcw_addr`, out, 7: note index to `music_dds`.
- `gate`, out, 1: DDS output enable for the mixer.
- `busy`, out, 1: high in PLAY or GAP.
- `note_done`, out, 1: one-cycle pulse when a note plus its gap completes normally.

## Operation
- The FSM has three states: IDLE, PLAY, GAP.
- IDLE:
  - `note_ready`=1.
  - On `note_valid`&`note_ready`: register `note_code` into `fcw_addr`, load the tick counter with max(`note_dur`,1), clear the prescaler, go to PLAY.
- PLAY:
  - `gate`=1 when `fcw_addr`≠0; `gate`=0 for a rest.
  - The prescaler counts 0..TICK_DIV-1. Each wrap is one tick and decrements the tick counter.
  - On the tick that takes the counter to 0: if GAP_TICKS>0, load GAP_TICKS and go to GAP; otherwise pulse `note_done` and go to IDLE.
- GAP:
  - `gate`=0, and `fcw_addr` holds the last note (no phase glitch into the DDS).
  - When the counter reaches 0, pulse `note_done` and go to IDLE.
- `stop` (any state):
  - Next state is IDLE, `gate`=0 on the next cycle, counters cleared, no `note_done`.
  - `fcw_addr` holds its value.
  - `stop` has priority over acceptance: `stop`&`note_valid` in IDLE accepts nothing.
- `note_ready`=0 in PLAY and GAP. Notes are not queued; upstream holds `note_valid` and data stable until accepted.
- Arithmetic and width rules:
  - The prescaler is $clog2(TICK_DIV) bits wide (min 1). The tick counter is max(DUR_W, $clog2(GAP_TICKS+1)) bits.
  - All counts are unsigned, with no wrap beyond the terminal values.
- `busy` = (state≠IDLE).

## Timing
- Reset values: state IDLE, `fcw_addr`=0, `gate`=0, `busy`=0, `note_done`=0, `note_ready`=1 (combinational from state), counters 0.
- `rst` asserted mid-note forces the reset values on the next edge, overriding `stop` and any handshake.
- An accept at edge k gives `fcw_addr`/`gate`/`busy` valid from cycle k+1. There is zero bubble between handshake and sound.
- PLAY lasts exactly max(`note_dur`,1)·TICK_DIV cycles. GAP lasts exactly GAP_TICKS·TICK_DIV cycles.
- `note_done` is high for one cycle, on the same edge the state enters IDLE. `note_ready` rises that same cycle, so back-to-back notes are accepted on the following edge.
- Note period with a continuously valid source: (max(dur,1)+GAP_TICKS)·TICK_DIV + 1 cycles (one IDLE cycle for the handshake).
- All outputs except `note_ready` are registered.

## Structure
- Package `music_pkg`:
  - state enum `seq_state_t` {IDLE, PLAY, GAP};
  - constant `REST_NOTE` = 7'd0;
  - constant `NOTE_W` = 7 (shared with the FCW table).
- Sub-module `tick_prescaler`: a counter with `clr` input and one-cycle `tick` output at TICK_DIV-1.
- The FSM and tick counter stay in `music_note_seq`.
- Top level: `music_note_seq.fcw_addr` → `music_dds.fcw_addr`; `gate` goes to the mixer.

## Test plan
All scenarios use TICK_DIV=4, GAP_TICKS=2, DUR_W=8.
- Reset, then a single note: after reset all outputs equal their reset values with `note_ready`=1. Accept code 60, dur 3 → `fcw_addr`=60 and `gate`=1 for exactly 12 cycles, `gate`=0 for 8 cycles, `note_done` pulse at cycle 21 after accept.
- Back-to-back: codes 60/64/67 with dur 1 and `note_valid` held → each accepted 1 cycle after the previous `note_done`; note period 13 cycles.
- dur=0 and rest: code 62 dur 0 → PLAY lasts 4 cycles. Code 0 dur 2 → `gate`=0 for the whole 8-cycle PLAY, `busy`=1.
- `stop` at cycle 5 of a dur-3 note → IDLE on the next edge, `gate`=0, `fcw_addr` stays 60, no `note_done`. `stop` asserted with `note_valid` in IDLE → no accept.
- GAP_TICKS=0 build: code 72 dur 2 → 8 cycles of PLAY, then `note_done` and IDLE directly.
- `rst` mid-GAP → next cycle shows reset values (`fcw_addr`=0, `gate`=0, `busy`=0), with no `note_done`.
